cmult_seq_ctrl: RTL and testbench
=================================

Name: cmult_seq_ctrl

Overview:
- Top-level sequencer for the complex multiplier datapath.
- Collects four operand words (a_re, a_im, b_re, b_im) from the host over the level-handshake read interface, fires the multiplier, and returns the two result words (p_re, p_im) over a level-handshake write interface.
- Sits between the host I/O pins and the multiplier core; it does no arithmetic.

Parameters:
- WIDTH, 16, operand word width in bits.
- RES_WIDTH, 2*WIDTH+1, result word width in bits (full-precision complex product).
- TIMEOUT, 255, maximum cycles in MULT_WAIT before abort; 8-bit counter, legal range 1..255.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; sampled in IDLE to start a transaction.
- in_hs  in  1  host input handshake (host raises when in_data is valid, lowers after seeing in_read).
- in_data  in  WIDTH  host operand word.
- in_read  out  1  one-cycle pulse: word captured.
- op_a_re, op_a_im, op_b_re, op_b_im  out  WIDTH each  registered operands to multiplier.
- mult_start  out  1  one-cycle pulse to multiplier.
- mult_done  in  1  multiplier completion, sampled only in MULT_WAIT.
- mult_re, mult_im  in  RES_WIDTH each  multiplier results, valid when mult_done=1.
- out_data  out  RES_WIDTH  result word to host.
- out_hs  out  1  level: out_data valid.
- out_ack  in  1  host acknowledge (level).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- timeout_err  out  1  sticky; cleared on next accepted run.

Behaviour:
- Reset: state=IDLE; all outputs and registers 0 (operands, out_data, result latches, counters, timeout_err).
- States: IDLE, RD_WAIT_1, RD_WAIT_0, MULT_START, MULT_WAIT, WR_WAIT_1, WR_WAIT_0, DONE.
- IDLE:
  - On run=1, clear word_cnt to 0 and timeout_err to 0, then go to RD_WAIT_1.
  - run=0: hold.
- RD_WAIT_1:
  - On in_hs=1, latch in_data into the operand selected by word_cnt (0=a_re, 1=a_im, 2=b_re, 3=b_im).
  - In the same edge, assert in_read for exactly one cycle and go to RD_WAIT_0.
- RD_WAIT_0:
  - On in_hs=0: if word_cnt=3, go to MULT_START; else word_cnt+1 and go to RD_WAIT_1.
  - in_hs held high: remain; no further in_read pulses.
- MULT_START:
  - mult_start=1 for exactly this one cycle.
  - Clear timeout counter; go to MULT_WAIT.
- MULT_WAIT:
  - On mult_done=1, latch mult_re and mult_im; set out_data=mult_re, word_cnt=0; go to WR_WAIT_1.
  - Otherwise increment the counter. When it reaches TIMEOUT, set timeout_err=1 and go to IDLE with no done pulse.
  - mult_done outside MULT_WAIT is ignored.
- WR_WAIT_1:
  - out_hs=1 (registered, asserted on entry).
  - On out_ack=1, drop out_hs next cycle and go to WR_WAIT_0.
- WR_WAIT_0:
  - On out_ack=0: if word_cnt=0, set word_cnt=1, out_data=latched im, go to WR_WAIT_1; else go to DONE.
- DONE:
  - done=1 for this one cycle, then go to IDLE.
  - out_data holds the last value until the next result load.
- Latencies:
  - in_read is asserted on the edge after in_hs is sampled high.
  - Minimum full transaction with immediate partners: 4×2 read + 1 start + ≥1 wait + 2×2 write + 1 done.
- Boundary conditions:
  - run held high through DONE re-arms on the next IDLE cycle (back-to-back transactions are allowed).
  - in_hs and out_ack are ignored in states that don't sample them.
  - Asynchronous reset mid-transaction aborts immediately: out_hs=0, no done pulse, partial operands cleared.
  - Operand registers hold their values after the transaction ends.
  - mult_done arriving in the same cycle that the counter hits TIMEOUT: done wins, no error.

Test Plan:
- Basic: run=1; host supplies 0x0003, 0x0004, 0x0002, 0xFFFF with one-cycle handshakes; model multiplier returns 10, 5 after 3 cycles -> four in_read pulses; operands 3, 4, 2, -1; one mult_start; out_data 10 then 5 with out_hs; one done pulse; busy falls in IDLE.
- Slow host: in_hs held high 5 cycles per word -> exactly one in_read per word; word_cnt advances only after in_hs falls.
- Timeout: TIMEOUT=8, mult_done never asserted -> timeout_err=1 eight cycles after mult_start; return to IDLE; no done; next run clears timeout_err.
- Race: mult_done asserted on the cycle the counter reaches TIMEOUT -> result is written, timeout_err stays 0.
- Reset mid-write: assert reset while out_hs=1 -> out_hs=0 and state IDLE immediately; no done; a fresh transaction then completes normally.
- Back-to-back: run held at 1 across two transactions with different operands -> two done pulses separated by one IDLE cycle; second results correct.

Source files
------------

// File: rtl/cmult_seq_ctrl_if.sv
// Host, multiplier and status signals of the complex-multiplier sequencer.
// master: host/multiplier side that drives the sequencer inputs.
// slave : the sequencer itself.
interface cmult_seq_ctrl_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RES_WIDTH = 2 * WIDTH + 1
);
    logic                 run;
    logic                 in_hs;
    logic [WIDTH-1:0]     in_data;
    logic                 in_read;
    logic [WIDTH-1:0]     op_a_re;
    logic [WIDTH-1:0]     op_a_im;
    logic [WIDTH-1:0]     op_b_re;
    logic [WIDTH-1:0]     op_b_im;
    logic                 mult_start;
    logic                 mult_done;
    logic [RES_WIDTH-1:0] mult_re;
    logic [RES_WIDTH-1:0] mult_im;
    logic [RES_WIDTH-1:0] out_data;
    logic                 out_hs;
    logic                 out_ack;
    logic                 busy;
    logic                 done;
    logic                 timeout_err;

    modport master (
        output run, in_hs, in_data, mult_done, mult_re, mult_im, out_ack,
        input  in_read, op_a_re, op_a_im, op_b_re, op_b_im, mult_start,
               out_data, out_hs, busy, done, timeout_err
    );

    modport slave (
        input  run, in_hs, in_data, mult_done, mult_re, mult_im, out_ack,
        output in_read, op_a_re, op_a_im, op_b_re, op_b_im, mult_start,
               out_data, out_hs, busy, done, timeout_err
    );
endinterface

// File: rtl/cmult_seq_ctrl.sv
// Sequencer for the complex multiplier: reads four operand words from the
// host, fires the multiplier, waits (with timeout) for its result and hands
// the real and imaginary result words back to the host. No arithmetic here.
module cmult_seq_ctrl #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RES_WIDTH = 2 * WIDTH + 1,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            reset,
    cmult_seq_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = 8;
    // Counter value in the last wait cycle before the timeout fires.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT_1,
        S_RD_WAIT_0,
        S_MULT_START,
        S_MULT_WAIT,
        S_WR_WAIT_1,
        S_WR_WAIT_0,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [1:0]           word_cnt_q;
    logic [CNT_W-1:0]     tmo_cnt_q;
    logic [WIDTH-1:0]     op_a_re_q;
    logic [WIDTH-1:0]     op_a_im_q;
    logic [WIDTH-1:0]     op_b_re_q;
    logic [WIDTH-1:0]     op_b_im_q;
    logic [RES_WIDTH-1:0] res_im_q;
    logic [RES_WIDTH-1:0] out_data_q;
    logic                 out_hs_q;
    logic                 in_read_q;
    logic                 mult_start_q;
    logic                 done_q;
    logic                 busy_q;
    logic                 timeout_err_q;

    // Transaction FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            word_cnt_q    <= 2'd0;
            tmo_cnt_q     <= '0;
            op_a_re_q     <= '0;
            op_a_im_q     <= '0;
            op_b_re_q     <= '0;
            op_b_im_q     <= '0;
            res_im_q      <= '0;
            out_data_q    <= '0;
            out_hs_q      <= 1'b0;
            in_read_q     <= 1'b0;
            mult_start_q  <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            in_read_q    <= 1'b0;
            mult_start_q <= 1'b0;
            done_q       <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.run) begin
                        word_cnt_q    <= 2'd0;
                        timeout_err_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= S_RD_WAIT_1;
                    end
                end

                S_RD_WAIT_1: begin
                    if (bus.in_hs) begin
                        case (word_cnt_q)
                            2'd0: op_a_re_q <= bus.in_data;
                            2'd1: op_a_im_q <= bus.in_data;
                            2'd2: op_b_re_q <= bus.in_data;
                            2'd3: op_b_im_q <= bus.in_data;
                        endcase
                        in_read_q <= 1'b1;
                        state_q   <= S_RD_WAIT_0;
                    end
                end

                // Wait for the host to drop in_hs so each word is read once.
                S_RD_WAIT_0: begin
                    if (!bus.in_hs) begin
                        if (word_cnt_q == 2'd3) begin
                            mult_start_q <= 1'b1;
                            state_q      <= S_MULT_START;
                        end else begin
                            word_cnt_q <= word_cnt_q + 2'd1;
                            state_q    <= S_RD_WAIT_1;
                        end
                    end
                end

                S_MULT_START: begin
                    tmo_cnt_q <= '0;
                    state_q   <= S_MULT_WAIT;
                end

                // A result in the final allowed cycle beats the timeout.
                S_MULT_WAIT: begin
                    if (bus.mult_done) begin
                        out_data_q <= bus.mult_re;
                        res_im_q   <= bus.mult_im;
                        word_cnt_q <= 2'd0;
                        out_hs_q   <= 1'b1;
                        state_q    <= S_WR_WAIT_1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                        if (tmo_cnt_q == TMO_LAST) begin
                            timeout_err_q <= 1'b1;
                            busy_q        <= 1'b0;
                            state_q       <= S_IDLE;
                        end
                    end
                end

                S_WR_WAIT_1: begin
                    if (bus.out_ack) begin
                        out_hs_q <= 1'b0;
                        state_q  <= S_WR_WAIT_0;
                    end
                end

                // Real part goes first, then the latched imaginary part.
                S_WR_WAIT_0: begin
                    if (!bus.out_ack) begin
                        if (word_cnt_q == 2'd0) begin
                            word_cnt_q <= 2'd1;
                            out_data_q <= res_im_q;
                            out_hs_q   <= 1'b1;
                            state_q    <= S_WR_WAIT_1;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    out_hs_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Drive the interface from the output registers.
    assign bus.in_read     = in_read_q;
    assign bus.op_a_re     = op_a_re_q;
    assign bus.op_a_im     = op_a_im_q;
    assign bus.op_b_re     = op_b_re_q;
    assign bus.op_b_im     = op_b_im_q;
    assign bus.mult_start  = mult_start_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_hs      = out_hs_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cmult_seq_ctrl.sv
// Bench for cmult_seq_ctrl: acts as host and multiplier, with the expected
// results computed as a plain complex product of the operand words.
module tb_cmult_seq_ctrl;

    localparam int unsigned W   = 16;
    localparam int unsigned RW  = 2 * W + 1;
    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cmult_seq_ctrl_if #(.WIDTH(W), .RES_WIDTH(RW)) bus ();

    cmult_seq_ctrl #(.WIDTH(W), .RES_WIDTH(RW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-precision complex product of {a_re,a_im,b_re,b_im}.
    task automatic cmul(input logic [63:0] ops, output logic [RW-1:0] pre, output logic [RW-1:0] pim);
        longint ar, ai, br, bi;
        logic [15:0] w;
        w = ops[63:48]; ar = longint'($signed(w));
        w = ops[47:32]; ai = longint'($signed(w));
        w = ops[31:16]; br = longint'($signed(w));
        w = ops[15:0];  bi = longint'($signed(w));
        pre = RW'(ar * br - ai * bi);
        pim = RW'(ar * bi + ai * br);
    endtask

    task automatic start_run(input bit keep_run);
        bus.run   = 1'b1;
        bus.in_hs = 1'b0;
        @(negedge clk);
        check("busy_on_start", 64'(bus.busy), 64'(1));
        check("tmo_err_cleared", 64'(bus.timeout_err), 64'(0));
        if (!keep_run) bus.run = 1'b0;
    endtask

    task automatic read_word(input logic [15:0] w, input int hold);
        int extra = 0;
        bus.in_hs     = 1'b1;
        bus.in_data   = w;
        bus.mult_done = 1'($urandom_range(0, 1));
        bus.mult_re   = RW'({$urandom, $urandom});
        bus.out_ack   = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("in_read_pulse", 64'(bus.in_read), 64'(1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            extra += int'(bus.in_read);
        end
        check("in_read_single", 64'(extra), 64'(0));
        bus.in_hs   = 1'b0;
        bus.in_data = 16'($urandom);
        @(negedge clk);
    endtask

    // lat = MULT_WAIT cycle (1-based) in which mult_done is raised; 0 = never.
    task automatic mult_phase(input logic [63:0] ops, input int lat,
                              input logic [RW-1:0] pre, input logic [RW-1:0] pim);
        bus.mult_done = 1'b0;
        bus.out_ack   = 1'b0;
        check("mult_start", 64'(bus.mult_start), 64'(1));
        check("op_a_re", 64'(bus.op_a_re), 64'(ops[63:48]));
        check("op_a_im", 64'(bus.op_a_im), 64'(ops[47:32]));
        check("op_b_re", 64'(bus.op_b_re), 64'(ops[31:16]));
        check("op_b_im", 64'(bus.op_b_im), 64'(ops[15:0]));
        if (lat == 0) begin
            for (int i = 1; i <= int'(TMO); i++) begin
                @(negedge clk);
                if (i == 1) check("mult_start_once", 64'(bus.mult_start), 64'(0));
                if (i == int'(TMO)) begin
                    check("tmo_not_early", 64'(bus.timeout_err), 64'(0));
                    check("busy_in_wait", 64'(bus.busy), 64'(1));
                end
            end
            @(negedge clk);
            check("tmo_err_set", 64'(bus.timeout_err), 64'(1));
            check("tmo_idle", 64'(bus.busy), 64'(0));
            check("tmo_no_done", 64'(bus.done), 64'(0));
            check("tmo_no_out_hs", 64'(bus.out_hs), 64'(0));
        end else begin
            for (int i = 1; i <= lat; i++) begin
                @(negedge clk);
                if (i == 1) check("mult_start_once", 64'(bus.mult_start), 64'(0));
            end
            bus.mult_done = 1'b1;
            bus.mult_re   = pre;
            bus.mult_im   = pim;
            @(negedge clk);
            bus.mult_done = 1'b0;
            bus.mult_re   = RW'({$urandom, $urandom});
            bus.mult_im   = RW'({$urandom, $urandom});
            check("no_tmo_err", 64'(bus.timeout_err), 64'(0));
        end
    endtask

    task automatic write_word(input logic [RW-1:0] exp, input int ack_hold, input bit last);
        bus.in_hs = 1'($urandom_range(0, 1));
        check("out_hs_up", 64'(bus.out_hs), 64'(1));
        check("out_data", 64'(bus.out_data), 64'(exp));
        for (int i = 0; i < ack_hold; i++) begin
            @(negedge clk);
            check("out_hs_hold", 64'(bus.out_hs), 64'(1));
        end
        bus.out_ack = 1'b1;
        @(negedge clk);
        check("out_hs_drop", 64'(bus.out_hs), 64'(0));
        bus.out_ack = 1'b0;
        @(negedge clk);
        if (last) begin
            check("done_pulse", 64'(bus.done), 64'(1));
            check("busy_in_done", 64'(bus.busy), 64'(1));
            @(negedge clk);
            check("done_once", 64'(bus.done), 64'(0));
            check("busy_idle", 64'(bus.busy), 64'(0));
            check("out_data_held", 64'(bus.out_data), 64'(exp));
            bus.in_hs = 1'b0;
        end
    endtask

    task automatic do_txn(input logic [63:0] ops, input int hold, input int lat,
                          input int ack_hold, input bit keep_run);
        logic [RW-1:0] pre, pim;
        cmul(ops, pre, pim);
        start_run(keep_run);
        for (int k = 0; k < 4; k++) read_word(ops[63-16*k -: 16], hold);
        mult_phase(ops, lat, pre, pim);
        if (lat > 0) begin
            write_word(pre, ack_hold, 1'b0);
            write_word(pim, ack_hold, 1'b1);
        end
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [63:0] ops;
        logic [RW-1:0] pre, pim;
        reset         = 1'b1;
        bus.run       = 1'b0;
        bus.in_hs     = 1'b0;
        bus.in_data   = '0;
        bus.mult_done = 1'b0;
        bus.mult_re   = '0;
        bus.mult_im   = '0;
        bus.out_ack   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_out_hs", 64'(bus.out_hs), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_tmo_err", 64'(bus.timeout_err), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_op_a_re", 64'(bus.op_a_re), 64'(0));
        check("rst_in_read", 64'(bus.in_read), 64'(0));
        check("rst_mult_start", 64'(bus.mult_start), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Basic: 3+4j times 2-1j.
        do_txn(64'h0003_0004_0002_FFFF, 0, 3, 0, 1'b0);

        // Slow host: in_hs high five cycles per word.
        do_txn({$urandom, $urandom}, 4, 2, 1, 1'b0);

        // Timeout with no mult_done, then sticky error cleared by next run.
        ops = {$urandom, $urandom};
        start_run(1'b0);
        for (int k = 0; k < 4; k++) read_word(ops[63-16*k -: 16], 0);
        mult_phase(ops, 0, '0, '0);
        @(negedge clk);
        check("tmo_err_sticky", 64'(bus.timeout_err), 64'(1));
        do_txn({$urandom, $urandom}, 0, 1, 0, 1'b0);

        // Race: result arrives in the last allowed wait cycle.
        do_txn({$urandom, $urandom}, 1, int'(TMO), 0, 1'b0);

        // Reset while out_hs is high, then a fresh transaction.
        ops = {$urandom, $urandom};
        cmul(ops, pre, pim);
        start_run(1'b0);
        for (int k = 0; k < 4; k++) read_word(ops[63-16*k -: 16], 0);
        mult_phase(ops, 2, pre, pim);
        check("pre_rst_out_hs", 64'(bus.out_hs), 64'(1));
        reset = 1'b1;
        #1;
        check("mid_rst_out_hs", 64'(bus.out_hs), 64'(0));
        check("mid_rst_busy", 64'(bus.busy), 64'(0));
        check("mid_rst_op_a_re", 64'(bus.op_a_re), 64'(0));
        check("mid_rst_op_b_im", 64'(bus.op_b_im), 64'(0));
        check("mid_rst_out_data", 64'(bus.out_data), 64'(0));
        @(negedge clk);
        check("mid_rst_no_done", 64'(bus.done), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_no_done", 64'(bus.done), 64'(0));
        check("post_rst_idle", 64'(bus.busy), 64'(0));
        do_txn({$urandom, $urandom}, 0, 1, 0, 1'b0);

        // Back-to-back with run held high; one IDLE cycle between them.
        do_txn({$urandom, $urandom}, 0, 1, 0, 1'b1);
        do_txn({$urandom, $urandom}, 0, 2, 1, 1'b1);
        bus.run = 1'b0;
        @(negedge clk);
        check("b2b_stays_idle", 64'(bus.busy), 64'(0));

        // Randomised transactions; operands hold afterwards.
        for (int t = 0; t < 6; t++) begin
            ops = {$urandom, $urandom};
            do_txn(ops, int'($urandom_range(0, 3)), int'($urandom_range(1, TMO)),
                   int'($urandom_range(0, 2)), 1'b0);
            check("op_hold_a_re", 64'(bus.op_a_re), 64'(ops[63:48]));
            check("op_hold_b_im", 64'(bus.op_b_im), 64'(ops[15:0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
